// File: rtl/cpu_ctrl_pkg.sv
// Shared front-end control definitions: sequencer state encoding,
// PC width and the default reset PC of the word-addressed CPU.
package cpu_ctrl_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequencer states: normal fetch, pipeline drain after halt, stopped.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/perf_counters.sv
// Four free-running performance counters. cycle_cnt advances whenever
// run_en is high; the others advance on their single-cycle strobes.
// All counters wrap modulo 2^CNT_W.
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             jump_inc,
  input  logic             branch_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Count enabled cycles and event strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt  <= '0;
      jump_cnt   <= '0;
      branch_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (run_en)     cycle_cnt  <= cycle_cnt + CNT_W'(1);
      if (jump_inc)   jump_cnt   <= jump_cnt + CNT_W'(1);
      if (branch_inc) branch_cnt <= branch_cnt + CNT_W'(1);
      if (stall_inc)  stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and front-end pipeline control for the 5-stage CPU.
// Applies EX redirects, load-use bubbles and halt/drain sequencing, and
// keeps performance counters.
// Optional build macro PC_RESUME_EN: a resume pulse in HALTED restarts
// fetch at the instruction after the halt. Without it HALTED is terminal
// until rst and the resume input is unused.
//
// Control outputs are combinational from the current state and inputs;
// they describe what the pipeline registers do on the coming edge.
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          CNT_W        = 32,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             redirect_is_branch,
  input  logic             load_use,
  input  logic             halt_ex,
  input  logic [31:0]      ex_pc,
  input  logic             resume,
  output logic [31:0]      pc,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) + 1 : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [PC_W-1:0]    resume_pc;
  logic               jump_inc;
  logic               branch_inc;
  logic               stall_inc;
  logic               run_en;

  // Front-end controls and counter strobes; halt beats redirect beats load-use.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    jump_inc    = 1'b0;
    branch_inc  = 1'b0;
    stall_inc   = 1'b0;
    case (state)
      RUN: begin
        if (halt_ex) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (redirect_valid) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (redirect_is_branch) branch_inc = 1'b1;
          else                    jump_inc   = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end
      end
      default: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
    endcase
  end

  assign run_en = (state != HALTED);

  // Sequencer FSM, PC register, drain counter and registered halted flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      drain_cnt <= '0;
      resume_pc <= RESET_PC;
      halted    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_ex) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            resume_pc <= ex_pc + 32'd1;
          end else if (redirect_valid) begin
            pc <= redirect_target;
          end else if (!load_use) begin
            pc <= pc + 32'd1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DRAIN_W'(1);
          if (drain_cnt == DRAIN_LAST) state <= HALTED;
        end
        HALTED: begin
          halted <= 1'b1;
`ifdef PC_RESUME_EN
          if (resume) begin
            state  <= RUN;
            pc     <= resume_pc;
            halted <= 1'b0;
          end
`endif
        end
        default: state <= RUN;
      endcase
    end
  end

`ifndef PC_RESUME_EN
  // Resume is not wired to anything in this build.
  logic unused_resume;
  assign unused_resume = resume ^ (^resume_pc);
`endif

  perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf_counters (
    .clk       (clk),
    .rst       (rst),
    .run_en    (run_en),
    .jump_inc  (jump_inc),
    .branch_inc(branch_inc),
    .stall_inc (stall_inc),
    .cycle_cnt (cycle_cnt),
    .jump_cnt  (jump_cnt),
    .branch_cnt(branch_cnt),
    .stall_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: a vector table walked one cycle per
// entry, then hand-written sequences for resume, PC wrap and reset mid-drain.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_is_branch;
  logic        load_use;
  logic        halt_ex;
  logic [31:0] ex_pc;
  logic        resume;
  logic [31:0] pc;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] jump_cnt;
  logic [31:0] branch_cnt;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .redirect_is_branch(redirect_is_branch),
    .load_use          (load_use),
    .halt_ex           (halt_ex),
    .ex_pc             (ex_pc),
    .resume            (resume),
    .pc                (pc),
    .pc_en             (pc_en),
    .if_id_en          (if_id_en),
    .if_id_flush       (if_id_flush),
    .id_ex_flush       (id_ex_flush),
    .halted            (halted),
    .cycle_cnt         (cycle_cnt),
    .jump_cnt          (jump_cnt),
    .branch_cnt        (branch_cnt),
    .stall_cnt         (stall_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bundle order: {pc_en, if_id_en, if_id_flush, id_ex_flush}
  localparam logic [3:0] C_IDLE  = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_REDIR = 4'b1111;
  localparam logic [3:0] C_HALT  = 4'b0111;
  localparam logic [3:0] C_STOP  = 4'b0011;

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        br;
    logic        lu;
    logic        hx;
    logic [31:0] epc;
    logic [31:0] e_pc;
    logic [3:0]  e_ctl;
    logic        e_halted;
    logic [31:0] e_cyc;
    logic [31:0] e_jmp;
    logic [31:0] e_br;
    logic [31:0] e_stl;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic rv, logic [31:0] tgt, logic br, logic lu,
                              logic hx, logic [31:0] epc, logic [31:0] p,
                              logic [3:0] c, logic h, logic [31:0] cy,
                              logic [31:0] j, logic [31:0] b, logic [31:0] s);
    vec_t v;
    v.rv = rv; v.tgt = tgt; v.br = br; v.lu = lu; v.hx = hx; v.epc = epc;
    v.e_pc = p; v.e_ctl = c; v.e_halted = h;
    v.e_cyc = cy; v.e_jmp = j; v.e_br = b; v.e_stl = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    redirect_valid     = 1'b0;
    redirect_target    = 32'h0;
    redirect_is_branch = 1'b0;
    load_use           = 1'b0;
    halt_ex            = 1'b0;
    ex_pc              = 32'h0;
    resume             = 1'b0;
  endtask

  task automatic check_ctl(input string name, input logic [3:0] exp);
    check(name, {28'h0, pc_en, if_id_en, if_id_flush, id_ex_flush}, {28'h0, exp});
  endtask

  task automatic check_cnts(input string name, input logic [31:0] cy,
                            input logic [31:0] j, input logic [31:0] b,
                            input logic [31:0] s);
    check({name, "_cyc"}, cycle_cnt, cy);
    check({name, "_jmp"}, jump_cnt, j);
    check({name, "_br"},  branch_cnt, b);
    check({name, "_stl"}, stall_cnt, s);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pre-edge expectations for each cycle; a row's effect shows in the next row.
    //             rv  tgt       br  lu  hx  epc      | pc        ctl      h  cyc j  b  s
    vecs[0]  = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  C_IDLE,  0, 0,  0, 0, 0);
    vecs[1]  = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h1,  C_IDLE,  0, 1,  0, 0, 0);
    vecs[2]  = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h2,  C_IDLE,  0, 2,  0, 0, 0);
    vecs[3]  = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h3,  C_IDLE,  0, 3,  0, 0, 0);
    vecs[4]  = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h4,  C_IDLE,  0, 4,  0, 0, 0);
    vecs[5]  = mk(0, 32'h0,   0, 1, 0, 32'h0,  32'h5,  C_STALL, 0, 5,  0, 0, 0);
    vecs[6]  = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h5,  C_IDLE,  0, 6,  0, 0, 1);
    vecs[7]  = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h6,  C_IDLE,  0, 7,  0, 0, 1);
    vecs[8]  = mk(1, 32'h40,  1, 0, 0, 32'h0,  32'h7,  C_REDIR, 0, 8,  0, 0, 1);
    vecs[9]  = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h40, C_IDLE,  0, 9,  0, 1, 1);
    vecs[10] = mk(1, 32'h10,  0, 1, 0, 32'h0,  32'h41, C_REDIR, 0, 10, 0, 1, 1);
    vecs[11] = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h10, C_IDLE,  0, 11, 1, 1, 1);
    vecs[12] = mk(1, 32'h99,  0, 0, 1, 32'h20, 32'h11, C_HALT,  0, 12, 1, 1, 1);
    vecs[13] = mk(1, 32'h55,  1, 1, 1, 32'h30, 32'h11, C_STOP,  0, 13, 1, 1, 1);
    vecs[14] = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h11, C_STOP,  0, 14, 1, 1, 1);
    vecs[15] = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h11, C_STOP,  0, 15, 1, 1, 1);
    vecs[16] = mk(0, 32'h0,   0, 0, 0, 32'h0,  32'h11, C_STOP,  1, 15, 1, 1, 1);
    vecs[17] = mk(1, 32'h77,  0, 1, 1, 32'h0,  32'h11, C_STOP,  1, 15, 1, 1, 1);

    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check_ctl("rst_ctl", C_IDLE);
    check_cnts("rst", 0, 0, 0, 0);
    rst = 1'b0;

    // Table-driven main sequence
    for (int i = 0; i < 18; i++) begin
      redirect_valid     = vecs[i].rv;
      redirect_target    = vecs[i].tgt;
      redirect_is_branch = vecs[i].br;
      load_use           = vecs[i].lu;
      halt_ex            = vecs[i].hx;
      ex_pc              = vecs[i].epc;
      #1;
      check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      check_ctl($sformatf("v%0d_ctl", i), vecs[i].e_ctl);
      check($sformatf("v%0d_halted", i), {31'h0, halted}, {31'h0, vecs[i].e_halted});
      check_cnts($sformatf("v%0d", i), vecs[i].e_cyc, vecs[i].e_jmp,
                 vecs[i].e_br, vecs[i].e_stl);
      @(negedge clk);
    end

    // Resume pulse while halted
    drive_idle();
    resume = 1'b1;
    #1;
    check("res_pre_pc", pc, 32'h11);
    @(negedge clk);
    resume = 1'b0;
    #1;
`ifdef PC_RESUME_EN
    check("res_pc", pc, 32'h21);
    check("res_halted", {31'h0, halted}, 32'h0);
    check_ctl("res_ctl", C_IDLE);
    check_cnts("res", 15, 1, 1, 1);
    @(negedge clk);
    #1;
    check("res_next_pc", pc, 32'h22);
    check("res_next_cyc", cycle_cnt, 32'd16);
`else
    check("nores_pc", pc, 32'h11);
    check("nores_halted", {31'h0, halted}, 32'h1);
    check_ctl("nores_ctl", C_STOP);
    check_cnts("nores", 15, 1, 1, 1);
    @(negedge clk);
    #1;
    check("nores_next_pc", pc, 32'h11);
`endif

    // Asynchronous reset, then PC wrap at the top of the address space
    rst = 1'b1;
    #1;
    check("rst2_pc", pc, 32'h0);
    check("rst2_halted", {31'h0, halted}, 32'h0);
    check_cnts("rst2", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_rel_pc", pc, 32'h0);
    @(negedge clk);
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    #1;
    check("wrap_redir_pc", pc, 32'h1);
    check_ctl("wrap_redir_ctl", C_REDIR);
    @(negedge clk);
    drive_idle();
    #1;
    check("wrap_top_pc", pc, 32'hFFFF_FFFF);
    check("wrap_jmp", jump_cnt, 32'd1);
    @(negedge clk);
    #1;
    check("wrap_zero_pc", pc, 32'h0);

    // Reset arriving mid-drain discards the halt and all counts
    halt_ex = 1'b1;
    ex_pc   = 32'h5;
    @(negedge clk);
    drive_idle();
    #1;
    check_ctl("mid_drain_ctl", C_STOP);
    check("mid_drain_cyc", cycle_cnt, 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_pc", pc, 32'h0);
    check_ctl("mid_rst_ctl", C_IDLE);
    check_cnts("mid_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_pc", pc, 32'h1);
    check("post_rst_cyc", cycle_cnt, 32'd1);
    check("post_rst_halted", {31'h0, halted}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
